// File: rtl/aud_pkg.sv
// Types and widths shared by the audio record path, AudDSP and the player.
package aud_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 20;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LRC,
    SHIFT,
    WRITE,
    PAUSED,
    DONE
  } rec_state_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// Brings the asynchronous codec ADC pins into the i_clk domain and derives
// the single-cycle bit-clock rising edge and left-channel frame start.
module i2s_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_bclk,
  input  logic i_lrc,
  input  logic i_data,
  output logic o_bclk_rise,
  output logic o_lrc_fall,
  output logic o_data
);

  logic [1:0] r_bclk_sync;
  logic [1:0] r_lrc_sync;
  logic [1:0] r_data_sync;
  logic       r_bclk_prev;
  logic       r_lrc_last;
  logic       w_bclk_rise;

  // lrc is remembered only at bit-clock rises, so a fall is judged between two consecutive codec bits
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bclk_sync <= '0;
      r_lrc_sync  <= '0;
      r_data_sync <= '0;
      r_bclk_prev <= 1'b0;
      r_lrc_last  <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[0], i_bclk};
      r_lrc_sync  <= {r_lrc_sync[0], i_lrc};
      r_data_sync <= {r_data_sync[0], i_data};
      r_bclk_prev <= r_bclk_sync[1];
      if (w_bclk_rise) begin
        r_lrc_last <= r_lrc_sync[1];
      end
    end
  end

  assign w_bclk_rise = r_bclk_sync[1] & ~r_bclk_prev;
  assign o_bclk_rise = w_bclk_rise;
  assign o_lrc_fall  = w_bclk_rise & ~r_lrc_sync[1] & r_lrc_last;
  assign o_data      = r_data_sync[1];

endmodule

// File: rtl/aud_recorder.sv
// Records the left channel of the WM8731 ADC I2S stream into SRAM and
// reports how many words the current recording holds.
module aud_recorder #(
  parameter int SAMPLE_W  = aud_pkg::SAMPLE_W,
  parameter int ADDR_W    = aud_pkg::ADDR_W,
  parameter int MAX_WORDS = 2 ** aud_pkg::ADDR_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  input  logic                i_bclk,
  input  logic                i_lrc,
  input  logic                i_data,
  output logic [ADDR_W-1:0]   o_sram_addr,
  output logic [SAMPLE_W-1:0] o_sram_data,
  output logic                o_sram_we,
  output logic [ADDR_W:0]     o_rec_len,
  output logic                o_busy,
  output logic                o_full
);

  import aud_pkg::*;

  localparam int                CNT_W    = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(SAMPLE_W - 1);
  localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W + 1)'(MAX_WORDS);

  rec_state_t r_state;
  rec_state_t w_next;

  logic                w_bclk_rise;
  logic                w_lrc_fall;
  logic                w_data;
  logic                w_last_bit;
  logic                w_fresh;
  logic [ADDR_W:0]     w_len_inc;

  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_len;
  logic [SAMPLE_W-1:0] r_shreg;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic [SAMPLE_W-1:0] r_sram_data;

  i2s_edge_sync u_sync (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_bclk      (i_bclk),
    .i_lrc       (i_lrc),
    .i_data      (i_data),
    .o_bclk_rise (w_bclk_rise),
    .o_lrc_fall  (w_lrc_fall),
    .o_data      (w_data)
  );

  assign w_last_bit = w_bclk_rise && (r_bit_cnt == LAST_BIT);
  assign w_len_inc  = r_len + 1'b1;
  assign w_fresh    = ((r_state == IDLE) || (r_state == DONE)) && (w_next == WAIT_LRC);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Control priority is stop > pause > start; WRITE always finishes before honouring either
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (!i_stop && i_start) w_next = WAIT_LRC;
      end
      WAIT_LRC: begin
        if (i_stop)          w_next = IDLE;
        else if (i_pause)    w_next = PAUSED;
        else if (w_lrc_fall) w_next = SHIFT;
      end
      SHIFT: begin
        if (i_stop)          w_next = IDLE;
        else if (i_pause)    w_next = PAUSED;
        else if (w_last_bit) w_next = WRITE;
      end
      WRITE: begin
        if (i_stop)                    w_next = IDLE;
        else if (i_pause)              w_next = PAUSED;
        else if (w_len_inc == MAX_LEN) w_next = DONE;
        else                           w_next = WAIT_LRC;
      end
      PAUSED: begin
        if (i_stop)       w_next = IDLE;
        else if (i_start) w_next = WAIT_LRC;
      end
      DONE: begin
        if (i_stop)       w_next = IDLE;
        else if (i_start) w_next = WAIT_LRC;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_sram_we = 1'b0;
    o_busy    = 1'b0;
    o_full    = 1'b0;
    case (r_state)
      WAIT_LRC: o_busy = 1'b1;
      SHIFT:    o_busy = 1'b1;
      WRITE: begin
        o_busy    = 1'b1;
        o_sram_we = 1'b1;
      end
      DONE:     o_full = 1'b1;
      default: ;
    endcase
  end

  // The write port is loaded while the final bit shifts in, so it is valid for the whole WRITE cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr       <= '0;
      r_len       <= '0;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_sram_addr <= '0;
      r_sram_data <= '0;
    end else begin
      if (w_fresh) begin
        r_ptr <= '0;
        r_len <= '0;
      end else if (r_state == WRITE) begin
        r_ptr <= r_ptr + 1'b1;
        r_len <= w_len_inc;
      end

      if ((r_state == WAIT_LRC) && (w_next == SHIFT)) begin
        r_bit_cnt <= '0;
      end else if ((r_state == SHIFT) && w_bclk_rise) begin
        r_shreg   <= {r_shreg[SAMPLE_W-2:0], w_data};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if ((r_state == SHIFT) && (w_next == WRITE)) begin
        r_sram_addr <= r_ptr;
        r_sram_data <= {r_shreg[SAMPLE_W-2:0], w_data};
      end
    end
  end

  assign o_sram_addr = r_sram_addr;
  assign o_sram_data = r_sram_data;
  assign o_rec_len   = r_len;

endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
- Record-side counterpart of the playback DSP path: AudDSP reads SRAM and feeds the DAC; aud_recorder deserialises the WM8731 ADC I2S stream and writes left-channel samples into SRAM.
- Sits between the codec ADC pins (BCLK/ADCLRCK/ADCDAT) and the SRAM write port.
- Exports the recorded length so the player knows where audio ends.
- Runs on the system clock and oversamples the codec bit clock.

Parameters:
- SAMPLE_W, 16, bits per sample, MSB first.
- ADDR_W, 20, SRAM word-address width.
- MAX_WORDS, 2**20, capacity in words; recording halts when reached.

Ports:
- i_clk  in  1  system clock, at least 4x i_bclk
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle pulse: begin new recording (from IDLE/DONE) or resume (from PAUSED)
- i_pause  in  1  one-cycle pulse: suspend recording
- i_stop  in  1  one-cycle pulse: end recording
- i_bclk  in  1  codec bit clock (asynchronous)
- i_lrc  in  1  codec ADCLRCK (asynchronous); low = left channel
- i_data  in  1  codec ADCDAT (asynchronous)
- o_sram_addr  out  ADDR_W  write address
- o_sram_data  out  SAMPLE_W  write data
- o_sram_we  out  1  one-cycle write strobe
- o_rec_len  out  ADDR_W+1  words written in the current recording
- o_busy  out  1  high in WAIT_LRC, SHIFT and WRITE
- o_full  out  1  high in DONE

Behaviour:
- Reset: state IDLE. All outputs are 0 (o_sram_addr, o_sram_data, o_sram_we, o_rec_len, o_busy, o_full). The internal word pointer and the shift register are cleared.
- Front end: i_bclk, i_lrc and i_data each pass through a 2-FF synchroniser.
- bclk_rise is one i_clk cycle long: sync_bclk=1 and the previous value was 0.
- All protocol actions occur only on the i_clk cycle where bclk_rise=1.
- lrc_fall means lrc sampled 0 at this bclk_rise and 1 at the previous bclk_rise.
- States:
  - IDLE: waits for start. On i_start: pointer=0, o_rec_len=0, go to WAIT_LRC.
  - WAIT_LRC: on lrc_fall, bit_cnt=0 and go to SHIFT. The edge carrying lrc_fall is the I2S one-bit delay slot; no data is captured on it.
  - SHIFT: on each bclk_rise, shreg = {shreg[SAMPLE_W-2:0], data} and bit_cnt++. After the 16th captured bit, go to WRITE.
  - WRITE: exactly one cycle with o_sram_we=1, o_sram_addr=pointer, o_sram_data=shreg. Next cycle: pointer++ and o_rec_len++. If the new o_rec_len equals MAX_WORDS, go to DONE; otherwise go to WAIT_LRC. Right-channel bits are ignored.
  - PAUSED: pointer and o_rec_len hold. On i_start, go to WAIT_LRC. The resumed recording continues at the same address.
  - DONE: o_full=1; incoming samples are ignored. i_stop goes to IDLE. i_start starts a fresh recording (pointer=0, o_rec_len=0).
- i_pause in WAIT_LRC or SHIFT: go to PAUSED and discard the partial sample.
- i_stop in any state except IDLE: go to IDLE. o_rec_len holds its final value until the next i_start from IDLE/DONE.
- Priority: i_stop > i_pause > i_start.
- Control pulses during WRITE: the write always completes and is counted, then the pending stop or pause takes effect on the following cycle.
- i_start while busy: ignored. i_pause in IDLE or DONE: ignored.
- o_sram_addr and o_sram_data hold their last values outside WRITE.
- o_sram_we is never asserted except in WRITE.
- Async reset at any point, including mid-SHIFT or during WRITE: immediately return to the reset state. No partial write is issued after reset.
- Pointer width is ADDR_W and never wraps, because DONE is entered first.

Decomposition:
- Package aud_pkg holds:
  - typedef enum rec_state_t {IDLE, WAIT_LRC, SHIFT, WRITE, PAUSED, DONE}
  - localparams SAMPLE_W=16, ADDR_W=20 (shared with AudDSP and the player).
- Sub-module i2s_edge_sync: the three 2-FF synchronisers plus generation of bclk_rise, lrc_fall and the synced data bit.
- aud_recorder instantiates i2s_edge_sync and contains the FSM, shift register and counters.

Test Plan:
- Single sample: i_clk 10 ns, bclk 80 ns; pulse i_start, then send left sample 16'hA5C3 and right sample 16'hFFFF → one o_sram_we pulse with addr 0 and data A5C3; o_rec_len=1.
- Stream: send 1024 left samples from a vector file (right channel random) → addresses 0..1023 are written in order, every data word matches the file, o_rec_len=1024. After i_stop: o_busy=0 and o_rec_len stays 1024.
- Pause mid-sample: pulse i_pause after 7 bits of sample #3 → no write for #3 and o_rec_len=3. Pulse i_start, send 16'h1234 → write at addr 3 with data 1234.
- Full: MAX_WORDS=8, send 10 samples → exactly 8 writes (addr 0..7), o_full=1, no further o_sram_we. A following i_start produces its next write at addr 0.
- Simultaneous: assert i_stop in the same cycle as the WRITE strobe for sample #5 → the write at addr 5 completes, o_rec_len=6, then IDLE.
- Reset mid-SHIFT: assert i_rst after 9 bits → all outputs 0 immediately, no o_sram_we afterwards, FSM in IDLE.
